// File: rtl/cdf_pipeline_pkg.sv
// cdf_pipeline_pkg: shared histogram-equalizer constants, FSM encoding and helpers
package cdf_pipeline_pkg;
  localparam int NUM_BINS = 256;
  localparam logic [15:0] VALID_TAG = 16'hAAAA;
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_e;
  function automatic logic [15:0] bin_addr(input logic base, input logic [7:0] bin);
    return {7'b0, base, bin};
  endfunction
  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction
endpackage

// File: rtl/cdf_pipeline_if.sv
// cdf_pipeline_if: histogram (m2) and CDF (m3) scratchpad bus between pipeline and memories
interface cdf_pipeline_if;
  logic [127:0] m2ReadVal;
  logic [15:0] m2ReadAddr;
  logic [15:0] m2WriteAddr;
  logic [127:0] m2WriteVal;
  logic m2WE;
  logic [15:0] m3WriteAddr;
  logic [127:0] m3WriteVal;
  logic m3WE;
  modport master(
    input m2ReadVal,
    output m2ReadAddr, m2WriteAddr, m2WriteVal, m2WE, m3WriteAddr, m3WriteVal, m3WE
  );
  modport slave(
    output m2ReadVal,
    input m2ReadAddr, m2WriteAddr, m2WriteVal, m2WE, m3WriteAddr, m3WriteVal, m3WE
  );
endinterface

// File: rtl/cdf_accumulate.sv
// cdf_accumulate: tag check plus saturating running sum, capturing the first nonzero sum
module cdf_accumulate
  import cdf_pipeline_pkg::*;
#(
  parameter logic [15:0] VALID_TAG = cdf_pipeline_pkg::VALID_TAG
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        vld_i,
  input  logic [31:0] word_i,
  output logic [15:0] sum_o,
  output logic [15:0] min_o
);
  logic [15:0] cnt, sum_q, sum_d, min_q, min_d;
  logic found_q, found_d;
  always_comb begin
    cnt = (word_i[31:16] == VALID_TAG) ? word_i[15:0] : 16'd0;
    sum_d = clr_i ? 16'd0 : vld_i ? sat_add(sum_q, cnt) : sum_q;
    found_d = clr_i ? 1'b0 : found_q | (vld_i && cnt != 16'd0);
    min_d = clr_i ? 16'd0 : (vld_i && cnt != 16'd0 && !found_q) ? sum_d : min_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      min_q <= '0;
      found_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      min_q <= min_d;
      found_q <= found_d;
    end
  end
  assign sum_o = sum_q;
  assign min_o = min_q;
endmodule

// File: rtl/cdf_pipeline.sv
// cdf_pipeline: streams histogram bins, writes the cumulative distribution and optionally clears bins
module cdf_pipeline
  import cdf_pipeline_pkg::*;
#(
  parameter int NUM_BINS = cdf_pipeline_pkg::NUM_BINS,
  parameter logic [15:0] VALID_TAG = cdf_pipeline_pkg::VALID_TAG
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         start,
  input  logic         inputBaseOffset,
  input  logic         clearEnable,
  input  logic [127:0] m2ReadVal,
  output logic [15:0]  m2ReadAddr,
  output logic [15:0]  m2WriteAddr,
  output logic [127:0] m2WriteVal,
  output logic         m2WE,
  output logic [15:0]  m3WriteAddr,
  output logic [127:0] m3WriteVal,
  output logic         m3WE,
  output logic [15:0]  cdfMin,
  output logic         done
);
  localparam int BW = NUM_BINS > 1 ? $clog2(NUM_BINS) : 1;
  localparam logic [BW-1:0] LAST = BW'(NUM_BINS - 1);
  state_e state_q;
  logic [BW-1:0] bin_q, rd_bin_q, acc_bin_q;
  logic base_q, clr_q, rd_vld_q, acc_vld_q, m2_we_q, m3_we_q, done_q;
  logic [15:0] wr_addr_q, sum;
  logic [127:0] m3_val_q;
  logic unused_hi;
  assign unused_hi = ^m2ReadVal[127:32];
  cdf_accumulate #(.VALID_TAG(VALID_TAG)) u_acc (
    .clk   (clock),
    .rst   (rst),
    .clr_i (state_q == IDLE && start),
    .vld_i (rd_vld_q),
    .word_i(m2ReadVal[31:0]),
    .sum_o (sum),
    .min_o (cdfMin)
  );
  // read address -> read data -> accumulated sum -> registered write: three stages after each issue
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= IDLE;
      bin_q <= '0;
      base_q <= 1'b0;
      clr_q <= 1'b0;
      rd_vld_q <= 1'b0;
      rd_bin_q <= '0;
      acc_vld_q <= 1'b0;
      acc_bin_q <= '0;
      m2_we_q <= 1'b0;
      m3_we_q <= 1'b0;
      wr_addr_q <= '0;
      m3_val_q <= '0;
      done_q <= 1'b0;
    end else begin
      rd_vld_q <= state_q == READ;
      rd_bin_q <= bin_q;
      acc_vld_q <= rd_vld_q;
      acc_bin_q <= rd_bin_q;
      m3_we_q <= acc_vld_q;
      m2_we_q <= acc_vld_q & clr_q;
      wr_addr_q <= acc_vld_q ? bin_addr(base_q, 8'(acc_bin_q)) : '0;
      m3_val_q <= acc_vld_q ? {96'b0, VALID_TAG, sum} : '0;
      case (state_q)
        IDLE: if (start) begin
          state_q <= READ;
          bin_q <= '0;
          base_q <= inputBaseOffset;
          clr_q <= clearEnable;
        end
        READ: begin
          bin_q <= bin_q + 1'b1;
          if (bin_q == LAST) state_q <= DRAIN;
        end
        // writes are contiguous, so the final one is the write with nothing behind it
        DRAIN: if (m3_we_q && !acc_vld_q) begin
          state_q <= DONE;
          done_q <= 1'b1;
        end
        DONE: if (!start) begin
          state_q <= IDLE;
          done_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign m2ReadAddr = (state_q == READ) ? bin_addr(base_q, 8'(bin_q)) : '0;
  assign m2WriteAddr = wr_addr_q;
  assign m2WriteVal = '0;
  assign m2WE = m2_we_q;
  assign m3WriteAddr = wr_addr_q;
  assign m3WriteVal = m3_val_q;
  assign m3WE = m3_we_q;
  assign done = done_q;
endmodule
